store_buffer: RTL

Posted-write buffer between the store data formatter and the data-memory port. Accepts one formatted store per cycle (address, data, SB/SH/SW control), aligns the data to its byte lanes, and generates a 4-bit write strobe. It queues up to DEPTH stores and drains them to memory over a valid/ready handshake. It flags loads that hit a pending store word so the core can stall, and rejects misaligned or illegal stores.

---
 rtl/store_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns SB/SH/SW stores to byte lanes, queues them
// in a DEPTH-entry FIFO, drains over valid/ready and flags load-word hazards.
module sb_hazard_lane (
  input  logic        vld,
  input  logic [29:0] ent_word,
  input  logic [29:0] ld_word,
  output logic        hit
);
  assign hit = vld & (ent_word == ld_word);
endmodule

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [1:0]                 store_control,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hazard,
  output logic                       mem_valid,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_ready,
  output logic                       st_error,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             st_error_q, st_error_d;
  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        fmt, head_e;
  logic             legal, full, push, pop;
  logic [DEPTH-1:0] hits;
  logic             ld_unused;

  assign ld_unused = ^ld_addr[1:0];

  always_comb begin
    fmt      = '0;
    fmt.addr = st_addr[31:2];
    fmt.data = st_data;
    legal    = 1'b0;
    case (store_control)
      2'b00: begin
        fmt.data = {4{st_data[7:0]}};
        fmt.strb = 4'b0001 << st_addr[1:0];
        legal    = 1'b1;
      end
      2'b01: begin
        fmt.data = {2{st_data[15:0]}};
        fmt.strb = st_addr[1] ? 4'b1100 : 4'b0011;
        legal    = ~st_addr[0];
      end
      2'b10: begin
        fmt.strb = 4'b1111;
        legal    = (st_addr[1:0] == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end

  // st_ready comes from registered count only, keeping mem_ready off its path
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = ~full;
  assign push     = st_valid & st_ready & legal;
  assign pop      = mem_valid & mem_ready;

  always_comb begin
    head_d     = pop  ? head_q + AW'(1) : head_q;
    tail_d     = push ? tail_q + AW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    st_error_d = st_valid & st_ready & ~legal;
    vld_d      = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      st_error_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      st_error_q <= st_error_d;
    end
  end

  // storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) ent_q[tail_q] <= fmt;
  end

  assign head_e    = ent_q[head_q];
  assign mem_valid = ~empty;
  assign mem_addr  = empty ? 32'h0 : {head_e.addr, 2'b00};
  assign mem_wdata = empty ? 32'h0 : head_e.data;
  assign mem_wstrb = empty ? 4'h0  : head_e.strb;
  assign st_error  = st_error_q;
  assign count     = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    sb_hazard_lane u_lane (
      .vld      (vld_q[i]),
      .ent_word (ent_q[i].addr),
      .ld_word  (ld_addr[31:2]),
      .hit      (hits[i])
    );
  end

  assign ld_hazard = ld_valid & (|hits);
endmodule
